// File: rtl/tile_map_buffer_pkg.sv
// Shared types and geometry helpers for the double-buffered tile-map store.
// Optional COPY_ON_SWAP_EN adds the COPY engine state used by the top level.
package tile_map_pkg;

    localparam int DEF_COLS    = 14;
    localparam int DEF_ROWS    = 8;
    localparam int DEF_TILE_W  = 120;
    localparam int DEF_TILE_H  = 60;
    localparam int DEF_PAD     = 8;
    localparam int DEF_COORD_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_COPY  = 2'd2
    } state_t;

    function automatic int line_w(input int cols, input int tile_w, input int pad);
        return cols * tile_w + 2 * pad;
    endfunction

endpackage

// File: rtl/tile_map_buffer_if.sv
// Tile-write handshake bundle: valid/ready request plus error pulse back.
// The master drives the request, the frame store is the slave.
interface tile_map_buffer_if #(
    parameter int COORD_W = 8
) ();

    logic               wr_valid;
    logic               wr_ready;
    logic [COORD_W-1:0] wr_x;
    logic [COORD_W-1:0] wr_y;
    logic               wr_data;
    logic               wr_err;

    modport master (
        output wr_valid, wr_x, wr_y, wr_data,
        input  wr_ready, wr_err
    );

    modport slave (
        input  wr_valid, wr_x, wr_y, wr_data,
        output wr_ready, wr_err
    );

endinterface

// File: rtl/tile_line_expander.sv
// Combinational expansion of one tile-map word into a padded pixel line.
// Column 0 lands on the MSB side; pad pixels on both ends stay zero.
module tile_line_expander
    import tile_map_pkg::*;
#(
    parameter  int COLS   = DEF_COLS,
    parameter  int TILE_W = DEF_TILE_W,
    parameter  int PAD    = DEF_PAD,
    localparam int LINE_W = line_w(COLS, TILE_W, PAD)
) (
    input  logic [COLS-1:0]   i_word,
    output logic [LINE_W-1:0] o_line
);

    always_comb begin
        o_line = '0;
        for (int c = 0; c < COLS; c++) begin
            o_line[LINE_W-1-PAD-c*TILE_W -: TILE_W] = {TILE_W{i_word[c]}};
        end
    end

endmodule

// File: rtl/tile_map_buffer.sv
// Double-buffered tile-map frame store with vsync-synchronised bank swap and clear engine.
// Define COPY_ON_SWAP_EN to refill the draw bank from the shown frame after each swap.
module tile_map_buffer
    import tile_map_pkg::*;
#(
    parameter  int COLS    = DEF_COLS,
    parameter  int ROWS    = DEF_ROWS,
    parameter  int TILE_W  = DEF_TILE_W,
    parameter  int TILE_H  = DEF_TILE_H,
    parameter  int PAD     = DEF_PAD,
    parameter  int COORD_W = DEF_COORD_W,
    localparam int LINE_W  = line_w(COLS, TILE_W, PAD)
) (
    input  logic              clk,
    input  logic              reset_n,
    tile_map_buffer_if.slave  wr_if,
    input  logic              clear_req,
    input  logic              clear_val,
    input  logic              swap_req,
    input  logic              vsync,
    output logic              swap_done,
    output logic              busy,
    output logic              disp_bank,
    input  logic [8:0]        row,
    output logic [LINE_W-1:0] line
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    logic [COLS-1:0]   r_bank [2][ROWS];
    state_t            r_state;
    state_t            w_state_nxt;
    logic [RW-1:0]     r_cnt;
    logic [RW-1:0]     w_cnt_nxt;
    logic              r_disp;
    logic              r_pend;
    logic              r_ready;
    logic              r_err;
    logic              r_done;
    logic              r_clr_val;
    logic [LINE_W-1:0] r_line;

    logic              w_idle;
    logic              w_acc;
    logic              w_inr;
    logic              w_swap;
    logic              w_draw;
    logic              w_vis;
    logic [RW-1:0]     w_trow;
    logic [RW-1:0]     w_wy;
    logic [CW-1:0]     w_wx;
    logic [COLS-1:0]   w_word;
    logic [LINE_W-1:0] w_exp;

    assign w_idle = (r_state == ST_IDLE);
    assign w_acc  = wr_if.wr_valid && r_ready;
    assign w_inr  = (wr_if.wr_x < COORD_W'(COLS)) && (wr_if.wr_y < COORD_W'(ROWS));
    assign w_swap = vsync && (r_pend || swap_req) && w_idle;
    assign w_draw = ~r_disp;
    assign w_wx   = CW'(wr_if.wr_x);
    assign w_wy   = RW'(wr_if.wr_y);

    assign w_trow = RW'(row / 9'(TILE_H));
    assign w_vis  = 32'(row) < 32'(ROWS * TILE_H);
    assign w_word = r_bank[r_disp][w_trow];

    tile_line_expander #(
        .COLS   (COLS),
        .TILE_W (TILE_W),
        .PAD    (PAD)
    ) u_exp (
        .i_word (w_word),
        .o_line (w_exp)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            ST_IDLE: begin
`ifdef COPY_ON_SWAP_EN
                if (w_swap) begin
                    w_state_nxt = ST_COPY;
                    w_cnt_nxt   = '0;
                end else
`endif
                if (clear_req) begin
                    w_state_nxt = ST_CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            ST_CLEAR, ST_COPY: begin
                if (r_cnt == RW'(ROWS - 1)) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // A write accepted alongside clear_req lands now; the engine overwrites it later.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < ROWS; r++) begin
                    r_bank[b][r] <= '1;
                end
            end
        end else begin
            if (w_acc && w_inr) begin
                r_bank[w_draw][w_wy][w_wx] <= wr_if.wr_data;
            end
            if (r_state == ST_CLEAR) begin
                r_bank[w_draw][r_cnt] <= {COLS{r_clr_val}};
            end
`ifdef COPY_ON_SWAP_EN
            if (r_state == ST_COPY) begin
                r_bank[w_draw][r_cnt] <= r_bank[r_disp][r_cnt];
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_disp    <= 1'b0;
            r_pend    <= 1'b0;
            r_ready   <= 1'b0;
            r_err     <= 1'b0;
            r_done    <= 1'b0;
            r_clr_val <= 1'b0;
            r_line    <= '0;
        end else begin
            r_ready <= (w_state_nxt == ST_IDLE);
            r_err   <= w_acc && !w_inr;
            r_done  <= w_swap;
            r_pend  <= (r_pend || swap_req) && !w_swap;
            if (w_swap) begin
                r_disp <= ~r_disp;
            end
            if (w_idle && clear_req) begin
                r_clr_val <= clear_val;
            end
            r_line <= w_vis ? w_exp : '0;
        end
    end

    assign wr_if.wr_ready = r_ready;
    assign wr_if.wr_err   = r_err;
    assign swap_done      = r_done;
    assign busy           = !w_idle;
    assign disp_bank      = r_disp;
    assign line           = r_line;

endmodule

// File: tb/tb_tile_map_buffer.sv
// Self-checking bench for tile_map_buffer: per-cycle model compare plus directed literal checks.
// Build with COPY_ON_SWAP_EN defined to exercise the copy-after-swap path too.
module tb_tile_map_buffer;
    import tile_map_pkg::*;

    localparam int COLS = 14;
    localparam int ROWS = 8;
    localparam int TW   = 120;
    localparam int TH   = 60;
    localparam int PAD  = 8;
    localparam int LW   = 1696;
`ifdef COPY_ON_SWAP_EN
    localparam bit COPY = 1'b1;
`else
    localparam bit COPY = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          clear_req;
    logic          clear_val;
    logic          swap_req;
    logic          vsync;
    logic [8:0]    row;
    logic          swap_done;
    logic          busy;
    logic          disp_bank;
    logic [LW-1:0] line;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    tile_map_buffer_if #(.COORD_W(8)) wif ();

    tile_map_buffer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_if     (wif),
        .clear_req (clear_req),
        .clear_val (clear_val),
        .swap_req  (swap_req),
        .vsync     (vsync),
        .swap_done (swap_done),
        .busy      (busy),
        .disp_bank (disp_bank),
        .row       (row),
        .line      (line)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic chkl(input string nm, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        int k;
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            k = 0;
            for (int i = LW - 1; i >= 0; i--) begin
                if (got[i] !== exp[i]) k = i;
            end
            $display("FAIL %s: line bit %0d got %b expected %b", nm, k, got[k], exp[k]);
        end
    endtask

    // Behavioural model: tile grid per bank, busy as a remaining-cycle count.
    bit            m_tile [2][ROWS][COLS];
    bit            m_disp;
    bit            m_pend;
    bit            m_ready;
    bit            m_err;
    bit            m_done;
    bit            m_valid = 1'b0;
    int            m_busy;
    logic [LW-1:0] m_line;

    function automatic logic [LW-1:0] mline(input int r, input bit b);
        logic [LW-1:0] l;
        l = '0;
        if (r < ROWS * TH) begin
            for (int p = PAD; p < PAD + COLS * TW; p++) begin
                l[LW-1-p] = m_tile[b][r/TH][(p-PAD)/TW];
            end
        end
        return l;
    endfunction

    always @(posedge clk) begin : model
        bit t [2][ROWS][COLS];
        bit acc;
        bit inr;
        bit idle;
        bit sw;
        bit nd;
        int nb;
        if (!reset_n) begin
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < ROWS; r++)
                    for (int c = 0; c < COLS; c++)
                        m_tile[b][r][c] <= 1'b1;
            m_disp  <= 1'b0;
            m_pend  <= 1'b0;
            m_ready <= 1'b0;
            m_err   <= 1'b0;
            m_done  <= 1'b0;
            m_busy  <= 0;
            m_line  <= '0;
            m_valid <= 1'b1;
        end else begin
            t = m_tile;
            m_line <= mline(int'(row), m_disp);
            acc = wif.wr_valid && m_ready;
            inr = (int'(wif.wr_x) < COLS) && (int'(wif.wr_y) < ROWS);
            if (acc && inr) t[!m_disp][int'(wif.wr_y)][int'(wif.wr_x)] = wif.wr_data;
            idle = (m_busy == 0);
            sw = vsync && (m_pend || swap_req) && idle;
            nd = sw ? !m_disp : m_disp;
            nb = idle ? 0 : m_busy - 1;
            if (sw && COPY) begin
                t[!nd] = t[nd];
                nb = ROWS;
            end else if (idle && clear_req) begin
                for (int r = 0; r < ROWS; r++)
                    for (int c = 0; c < COLS; c++)
                        t[!nd][r][c] = clear_val;
                nb = ROWS;
            end
            m_tile  <= t;
            m_disp  <= nd;
            m_pend  <= (m_pend || swap_req) && !sw;
            m_busy  <= nb;
            m_ready <= (nb == 0);
            m_err   <= acc && !inr;
            m_done  <= sw;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chkl("model_line", line, m_line);
            chk("model_disp", disp_bank, m_disp);
            chk("model_busy", busy, m_busy != 0);
            chk("model_ready", wif.wr_ready, m_ready);
            chk("model_err", wif.wr_err, m_err);
            chk("model_swap_done", swap_done, m_done);
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy !== 1'b0 || wif.wr_ready !== 1'b1) begin
            cyc();
            k++;
            if (k > 100) begin
                n_chk++;
                n_fail++;
                $display("FAIL wait_idle: busy=%b ready=%b expected ready=1", busy, wif.wr_ready);
                return;
            end
        end
    endtask

    task automatic wr(input int x, input int y, input bit d);
        wait_idle();
        wif.wr_valid = 1'b1;
        wif.wr_x     = 8'(x);
        wif.wr_y     = 8'(y);
        wif.wr_data  = d;
        cyc();
        wif.wr_valid = 1'b0;
    endtask

    task automatic swap_now();
        wait_idle();
        swap_req = 1'b1;
        vsync    = 1'b1;
        cyc();
        swap_req = 1'b0;
        vsync    = 1'b0;
    endtask

    task automatic count_busy(input string nm);
        int nb;
        nb = 0;
        while (busy === 1'b1 && nb < 50) begin
            nb++;
            cyc();
        end
        chk(nm, nb, 8);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [LW-1:0] zero;
        logic [LW-1:0] full;
        logic [LW-1:0] e;
        zero = '0;
        full = '0;
        full[LW-1-PAD:PAD] = '1;

        reset_n      = 1'b0;
        clear_req    = 1'b0;
        clear_val    = 1'b0;
        swap_req     = 1'b0;
        vsync        = 1'b0;
        row          = 9'd0;
        wif.wr_valid = 1'b0;
        wif.wr_x     = '0;
        wif.wr_y     = '0;
        wif.wr_data  = 1'b0;
        cyc(3);
        chk("rst_ready", wif.wr_ready, 0);
        chkl("rst_line", line, zero);
        chk("rst_busy", busy, 0);
        reset_n = 1'b1;
        cyc(2);
        chkl("init_line", line, full);
        chk("init_disp", disp_bank, 0);
        chk("init_ready", wif.wr_ready, 1);

        // single cleared tile shown after a same-cycle swap_req + vsync
        wr(3, 2, 1'b0);
        row = 9'd130;
        swap_now();
        chk("swap1_done", swap_done, 1);
        chk("swap1_disp", disp_bank, 1);
        cyc();
        e = full;
        e[1327:1208] = '0;
        chkl("swap1_line", line, e);

        // out-of-range writes flag wr_err and leave the bank alone
        wr(14, 0, 1'b0);
        chk("err_x14", wif.wr_err, 1);
        wr(0, 8, 1'b0);
        chk("err_y8", wif.wr_err, 1);
        wr(255, 1, 1'b0);
        chk("err_x255", wif.wr_err, 1);
        wr(1, 1, 1'b0);
        chk("err_inrange", wif.wr_err, 0);
        row = 9'd0;
        swap_now();
        cyc();
        chkl("oor_row0", line, full);
        row = 9'd60;
        cyc();
        e = full;
        e[1567:1448] = '0;
        chkl("oor_row60", line, e);

        // clear to zero with a colliding write, then show it
        wait_idle();
        clear_val    = 1'b0;
        clear_req    = 1'b1;
        wif.wr_valid = 1'b1;
        wif.wr_x     = 8'd5;
        wif.wr_y     = 8'd5;
        wif.wr_data  = 1'b1;
        cyc();
        clear_req    = 1'b0;
        wif.wr_valid = 1'b0;
        chk("clr_busy", busy, 1);
        chk("clr_ready", wif.wr_ready, 0);
        count_busy("clr_cycles");
        swap_now();
        for (int r = 0; r < ROWS; r++) begin
            row = 9'(r * TH + 7);
            cyc();
            chkl("cleared_row", line, zero);
        end

        // swap requests during clear defer and merge
        wait_idle();
        clear_val = 1'b1;
        clear_req = 1'b1;
        cyc();
        clear_req = 1'b0;
        swap_req  = 1'b1;
        cyc();
        swap_req  = 1'b0;
        vsync     = 1'b1;
        swap_req  = 1'b1;
        cyc();
        vsync     = 1'b0;
        swap_req  = 1'b0;
        chk("defer_done", swap_done, 0);
        chk("defer_disp", disp_bank, 1);
        wait_idle();
        cyc(2);
        swap_req = 1'b1;
        cyc();
        swap_req = 1'b0;
        vsync    = 1'b1;
        cyc();
        vsync    = 1'b0;
        chk("merged_done", swap_done, 1);
        chk("merged_disp", disp_bank, 0);
        wait_idle();
        vsync = 1'b1;
        cyc();
        vsync = 1'b0;
        chk("merged_once", swap_done, 0);
        chk("merged_disp2", disp_bank, 0);

        // rows past the map are blank
        row = 9'd480;
        cyc();
        chkl("row480", line, zero);
        row = 9'd511;
        cyc();
        chkl("row511", line, zero);
        row = 9'd479;
        cyc();

`ifdef COPY_ON_SWAP_EN
        wr(6, 4, 1'b0);
        row = 9'd240;
        swap_now();
        count_busy("copy_cycles1");
        swap_now();
        count_busy("copy_cycles2");
        e = full;
        e[967:848] = '0;
        chkl("copy_image", line, e);
`endif

        cyc(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tile_map_buffer.md
Name: tile_map_buffer

Overview:
Parametrised, fully clocked double-buffered tile-map frame store. It replaces the fixed 14x8 single-bit map generator. A draw bank accepts tile writes through a valid/ready handshake, and a display bank feeds pixel-line expansion to the display driver. Banks swap on request, synchronised to vertical sync, and a sequential engine clears the draw bank on request.

Parameters:
COLS, 14, tile columns per row (1..64)
ROWS, 8, tile rows (1..64)
TILE_W, 120, pixels per tile horizontally
TILE_H, 60, lines per tile vertically
PAD, 8, zero pixels on each side of the line
COORD_W, 8, width of x/y coordinate inputs
LINE_W, COLS*TILE_W+2*PAD (1696), derived output line width; must not be overridden

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
wr_valid  in  1  tile write request
wr_ready  out  1  write accepted this cycle when high with wr_valid
wr_x  in  COORD_W  tile column
wr_y  in  COORD_W  tile row
wr_data  in  1  tile value (1 = wall)
wr_err  out  1  one-cycle pulse: accepted write had out-of-range coordinates
clear_req  in  1  pulse: fill draw bank with clear_val
clear_val  in  1  fill value
swap_req  in  1  pulse: request bank swap
vsync  in  1  one-cycle pulse at start of vertical blank
swap_done  out  1  one-cycle pulse when swap executes
busy  out  1  clear/copy engine active
disp_bank  out  1  bank currently displayed
row  in  9  display line number
line  out  LINE_W  expanded pixel line for `row`

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-low.
- Reset values: both banks are all-ones (walls), disp_bank=0, swap pending=0, FSM=IDLE, line=0, wr_ready=0, wr_err=0, swap_done=0, busy=0.
- Storage: two banks of ROWS words, COLS bits each. Bit c of word r is tile (x=c, y=r). The draw bank is !disp_bank.
- FSM states:
  - IDLE: wr_ready=1.
  - CLEAR: lasts ROWS cycles. Writes row k on cycle k. busy=1, wr_ready=0. Returns to IDLE.
  - COPY: exists only with the optional feature; sequencing is the same as CLEAR.
- Write: the handshake completes when wr_valid && wr_ready. If wr_x<COLS and wr_y<ROWS, the draw-bank bit is updated at that edge. Otherwise the bank is untouched and wr_err pulses the next cycle.
- clear_req in IDLE enters CLEAR on the next edge. clear_req while busy is ignored. If a write and clear_req arrive in the same cycle, the write lands first and the clear then overwrites it.
- Swap:
  - swap_req sets pending. Repeated requests while pending merge into one swap.
  - On a vsync cycle with pending=1 and FSM=IDLE: disp_bank toggles, pending clears, and swap_done pulses the next cycle.
  - vsync while busy defers the swap to the next vsync after the engine returns to IDLE.
  - If swap_req and vsync arrive in the same cycle, the swap executes on that vsync.
  - A write accepted in the swap cycle goes to the pre-swap draw bank.
- Display read, registered with 1-cycle latency:
  - tile row = row / TILE_H.
  - line[LINE_W-1 -: PAD] = 0 and line[PAD-1:0] = 0.
  - Column c fills line[LINE_W-1-PAD-c*TILE_W -: TILE_W] with its bit, so column 0 is at the MSB side.
  - row >= ROWS*TILE_H gives line = 0.
  - Reads always use disp_bank as sampled in the same cycle.
- Width rules: divide and compare at 9 bits. Coordinates compare at COORD_W with no truncation, so x=255 is out of range and never aliased.

Optional Feature:
COPY_ON_SWAP_EN
- Defined: after each executed swap, the FSM enters COPY for ROWS cycles, copying the new display bank into the new draw bank row by row. busy=1 and wr_ready=0 during COPY. Pending swaps and clear_req during COPY are handled as for CLEAR. Incremental drawing therefore continues from the shown frame.
- Undefined: there is no COPY state, and the draw bank keeps its stale contents after a swap.

Decomposition:
- Package tile_map_pkg holds: FSM state enum (IDLE, CLEAR, COPY), the LINE_W derivation function, and default geometry constants.
- One sub-module, tile_line_expander, is combinational: it maps a COLS-bit word to the padded LINE_W line. The top level registers its output.

Test Plan:
- Reset, then row=0 -> after 1 cycle line has bits [1687:8] all 1 and pad bits all 0; disp_bank=0, wr_ready=1.
- Write x=3,y=2,data=0, then swap_req+vsync, then row=130 -> swap_done pulses; line bits [1327:1208] are 0 and all other tile bits are 1.
- Write x=14,y=0 (and x=0,y=8) -> wr_err pulses, no bank changes (checked after swap).
- clear_req with clear_val=0 -> busy high for 8 cycles, wr_ready=0; after a swap every row gives line=0. A write in the clear cycle is overwritten.
- swap_req during CLEAR, vsync on clear cycle 3 -> no swap. The next vsync after busy falls -> swap_done; three swap_req pulses give a single toggle.
- row=480 and row=511 -> line=0. With COPY_ON_SWAP_EN: swap -> busy for 8 cycles, and the draw bank equals the display bank (verified by a second swap with no writes showing an identical image).
